// File: rtl/serial_io_pkg.sv
// Shared constants for the serial IO bus decoder: FSM state codes, block offsets and channel limit.
package serial_io_pkg;

   localparam int unsigned MaxCh = 8;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StAck  = 2'd2;
   localparam logic [1:0] StHold = 2'd3;

   // Channel 0 sits at BASE_BLK; the control register follows the last channel.
   localparam logic [11:0] ChBlkOfs = 12'h000;

   function automatic logic [11:0] ctrl_blk_ofs(input int unsigned num_ch);
      return ChBlkOfs + 12'(num_ch);
   endfunction

endpackage

// File: rtl/sio_reset_pulse.sv
// Per-channel reset pulse generator: a trigger (re)loads the down-counter, output low while nonzero.
module sio_reset_pulse #(
   parameter int unsigned RstCyc = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   output logic rst_no
);

   localparam int unsigned CntW = $clog2(RstCyc + 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (trig_i) begin
         cnt_d = CntW'(RstCyc);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rst_no = (cnt_q == '0);

endmodule

// File: rtl/serial_io_bus_decoder.sv
// IO bus decoder for NUM_CH UART channels plus a per-channel reset control register.
// Optional macro SERIAL_IO_DECODE_ERR_EN turns unmapped/odd-byte accesses into Bus_Err_H strobes.
module serial_io_bus_decoder
   import serial_io_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter logic [11:0] BASE_BLK = 12'h020,
   parameter int unsigned WAIT_CYC = 2,
   parameter int unsigned RST_CYC  = 50000
) (
   input  logic              Clock,
   input  logic              Reset_H,
   input  logic [15:0]       Address,
   input  logic              IOSelect_H,
   input  logic              ByteSelect_L,
   input  logic              Write_L,
   input  logic [7:0]        DataIn,
   output logic [NUM_CH-1:0] Port_Enable,
   output logic [NUM_CH-1:0] Port_RST_n,
   output logic              IO_Ack_H,
   output logic              Bus_Err_H
);

   logic [11:0]       blk_ofs;
   logic              ch_hit, ctrl_hit;
   logic [NUM_CH-1:0] dec_en;
   logic [NUM_CH-1:0] trig;

   logic [1:0]        state_d, state_q;
   logic [3:0]        wait_cnt_d, wait_cnt_q;
   logic [NUM_CH-1:0] en_d, en_q;
   logic              ack_d, ack_q;
   logic              ctrl_wr_d, ctrl_wr_q;
   logic [NUM_CH-1:0] mask_d, mask_q;
   logic              err_d;

   logic unused_bits;
   assign unused_bits = ^{Address[3:0], DataIn};

   assign blk_ofs  = Address[15:4] - BASE_BLK - ChBlkOfs;
   assign ch_hit   = IOSelect_H && !ByteSelect_L && (blk_ofs < 12'(NUM_CH));
   assign ctrl_hit = IOSelect_H && !ByteSelect_L && (blk_ofs == ctrl_blk_ofs(NUM_CH));

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         dec_en[i] = ch_hit && (blk_ofs == 12'(i));
      end
   end

`ifdef SERIAL_IO_DECODE_ERR_EN
   logic bad_acc;
   logic err_q;
   assign bad_acc = IOSelect_H && !ch_hit && !ctrl_hit;
`endif

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      en_d       = en_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      ctrl_wr_d  = ctrl_wr_q;
      mask_d     = mask_q;
      case (state_q)
         StIdle: begin
            if (ch_hit || ctrl_hit) begin
               en_d      = dec_en;
               ctrl_wr_d = ctrl_hit && !Write_L;
               mask_d    = DataIn[NUM_CH-1:0];
               if (WAIT_CYC == 0) begin
                  state_d = StAck;
                  ack_d   = 1'b1;
               end else begin
                  state_d    = StWait;
                  wait_cnt_d = 4'(WAIT_CYC - 1);
               end
            end
`ifdef SERIAL_IO_DECODE_ERR_EN
            else if (bad_acc) begin
               state_d = StHold;
               err_d   = 1'b1;
            end
`endif
         end
         StWait: begin
            // Master gave up the cycle: abandon it without acknowledging.
            if (!IOSelect_H) begin
               state_d   = StIdle;
               en_d      = '0;
               ctrl_wr_d = 1'b0;
            end else if (wait_cnt_q == 4'd0) begin
               state_d = StAck;
               ack_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         StAck: begin
            state_d = StHold;
         end
         StHold: begin
            if (!IOSelect_H) begin
               state_d = StIdle;
               en_d    = '0;
            end
         end
         default: begin
            state_d = StIdle;
            en_d    = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         en_q       <= '0;
         ack_q      <= 1'b0;
         ctrl_wr_q  <= 1'b0;
         mask_q     <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         en_q       <= en_d;
         ack_q      <= ack_d;
         ctrl_wr_q  <= ctrl_wr_d;
         mask_q     <= mask_d;
      end
   end

`ifdef SERIAL_IO_DECODE_ERR_EN
   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign Bus_Err_H = err_q;
`else
   logic unused_err;
   assign unused_err = err_d;
   assign Bus_Err_H  = 1'b0;
`endif

   // Only the ACK cycle fires the triggers, so each control write acts once.
   assign trig = ((state_q == StAck) && ctrl_wr_q) ? mask_q : '0;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sio_reset_pulse #(
         .RstCyc(RST_CYC)
      ) u_rst_pulse (
         .clk_i (Clock),
         .rst_i (Reset_H),
         .trig_i(trig[i]),
         .rst_no(Port_RST_n[i])
      );
   end

   assign Port_Enable = en_q;
   assign IO_Ack_H    = ack_q;

endmodule

// File: tb/tb_serial_io_bus_decoder.sv
// Self-checking bench: directed scenarios then random bus cycles against a timeline model.
module tb_serial_io_bus_decoder;

   localparam int          NUM_CH = 4;
   localparam logic [11:0] BASE   = 12'h020;
   localparam int          WAIT   = 2;
   localparam int          RST    = 10;
`ifdef SERIAL_IO_DECODE_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic              Clock, Reset_H;
   logic [15:0]       Address;
   logic              IOSelect_H, ByteSelect_L, Write_L;
   logic [7:0]        DataIn;
   logic [NUM_CH-1:0] Port_Enable, Port_RST_n;
   logic              IO_Ack_H, Bus_Err_H;

   serial_io_bus_decoder #(
      .NUM_CH  (NUM_CH),
      .BASE_BLK(BASE),
      .WAIT_CYC(WAIT),
      .RST_CYC (RST)
   ) dut (
      .Clock       (Clock),
      .Reset_H     (Reset_H),
      .Address     (Address),
      .IOSelect_H  (IOSelect_H),
      .ByteSelect_L(ByteSelect_L),
      .Write_L     (Write_L),
      .DataIn      (DataIn),
      .Port_Enable (Port_Enable),
      .Port_RST_n  (Port_RST_n),
      .IO_Ack_H    (IO_Ack_H),
      .Bus_Err_H   (Bus_Err_H)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int deadline[NUM_CH];
   int lowcnt[NUM_CH];

   logic [NUM_CH-1:0] exp_en;
   logic              exp_ack, exp_err;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
   endtask

   // One clock: model reset effect at the edge, then compare all outputs mid-cycle.
   task automatic tick();
      logic [NUM_CH-1:0] exp_rst;
      @(posedge Clock);
      cyc++;
      if (Reset_H) foreach (deadline[i]) deadline[i] = 0;
      @(negedge Clock);
      for (int i = 0; i < NUM_CH; i++) begin
         exp_rst[i] = !(cyc < deadline[i]);
         if (Port_RST_n[i] === 1'b0) lowcnt[i]++;
      end
      check("port_enable", 8'(Port_Enable), 8'(exp_en));
      check("io_ack", 8'(IO_Ack_H), 8'(exp_ack));
      check("bus_err", 8'(Bus_Err_H), 8'(exp_err));
      check("port_rst_n", 8'(Port_RST_n), 8'(exp_rst));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // drop_wait >= 0 releases IOSelect_H after that many extra WAIT cycles.
   task automatic bus_cycle(input logic [15:0] a, input logic bs, input logic wr_l,
                            input logic [7:0] d, input int extra, input int drop_wait);
      int ch;
      bit is_ch, is_ctrl;
      ch      = int'(a[15:4]) - int'(BASE);
      is_ch   = !bs && ch >= 0 && ch < NUM_CH;
      is_ctrl = !bs && ch == NUM_CH;
      Address      = a;
      ByteSelect_L = bs;
      Write_L      = wr_l;
      DataIn       = d;
      IOSelect_H   = 1'b1;
      if (is_ch || is_ctrl) begin
         exp_en = is_ch ? NUM_CH'(1 << ch) : '0;
         if (drop_wait >= 0 && drop_wait < WAIT) begin
            repeat (drop_wait + 1) tick();
            IOSelect_H = 1'b0;
            exp_en     = '0;
            tick();
         end else begin
            repeat (WAIT) tick();
            exp_ack = 1'b1;
            tick();
            exp_ack = 1'b0;
            if (is_ctrl && !wr_l) begin
               for (int i = 0; i < NUM_CH; i++) if (d[i]) deadline[i] = cyc + 1 + RST;
            end
            tick();
            repeat (extra) tick();
            IOSelect_H = 1'b0;
            exp_en     = '0;
            tick();
         end
      end else begin
         if (ErrEn) begin
            exp_err = 1'b1;
            tick();
            exp_err = 1'b0;
         end else begin
            tick();
         end
         repeat (extra) tick();
         IOSelect_H = 1'b0;
         tick();
      end
      ByteSelect_L = 1'b1;
      Write_L      = 1'b1;
   endtask

   initial begin
      logic [11:0] blk;
      logic [15:0] a;
      int          dw;
      foreach (deadline[i]) deadline[i] = 0;
      foreach (lowcnt[i]) lowcnt[i] = 0;
      exp_en       = '0;
      exp_ack      = 1'b0;
      exp_err      = 1'b0;
      Reset_H      = 1'b1;
      Address      = 16'h0000;
      IOSelect_H   = 1'b0;
      ByteSelect_L = 1'b1;
      Write_L      = 1'b1;
      DataIn       = 8'h00;
      idle(2);
      Reset_H = 1'b0;
      idle(2);

      // Read of channel 1 with two wait states
      bus_cycle(16'h0210, 1'b0, 1'b1, 8'h00, 1, -1);
      idle(1);

      // Reset write to channels 0 and 2
      foreach (lowcnt[i]) lowcnt[i] = 0;
      bus_cycle(16'h0240, 1'b0, 1'b0, 8'h05, 0, -1);
      idle(12);
      check("low_ch0", 8'(lowcnt[0]), 8'd10);
      check("low_ch1", 8'(lowcnt[1]), 8'd0);
      check("low_ch2", 8'(lowcnt[2]), 8'd10);
      check("low_ch3", 8'(lowcnt[3]), 8'd0);

      // Retrigger channel 0 seven cycles into its pulse; upper data bits are ignored
      foreach (lowcnt[i]) lowcnt[i] = 0;
      bus_cycle(16'h0240, 1'b0, 1'b0, 8'h01, 2, -1);
      bus_cycle(16'h0247, 1'b0, 1'b0, 8'hF1, 0, -1);
      idle(20);
      check("retrig_low_ch0", 8'(lowcnt[0]), 8'd17);
      check("retrig_low_ch3", 8'(lowcnt[3]), 8'd0);

      // IOSelect_H released during WAIT
      bus_cycle(16'h0230, 1'b0, 1'b1, 8'h00, 0, 0);
      bus_cycle(16'h0245, 1'b0, 1'b0, 8'h0F, 0, 1);
      idle(2);

      // Unmapped block and odd-byte access
      bus_cycle(16'h0250, 1'b0, 1'b1, 8'h00, 1, -1);
      bus_cycle(16'h0200, 1'b1, 1'b0, 8'h00, 0, -1);
      bus_cycle(16'h01F0, 1'b0, 1'b1, 8'h00, 0, -1);
      idle(1);

      // Reset during an active pulse and during WAIT
      bus_cycle(16'h0240, 1'b0, 1'b0, 8'h0F, 0, -1);
      idle(2);
      Address      = 16'h0200;
      ByteSelect_L = 1'b0;
      IOSelect_H   = 1'b1;
      exp_en       = 4'b0001;
      tick();
      Reset_H = 1'b1;
      exp_en  = '0;
      tick();
      Reset_H      = 1'b0;
      IOSelect_H   = 1'b0;
      ByteSelect_L = 1'b1;
      idle(3);

      // Random bus cycles
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0, 1:    blk = BASE + 12'($urandom_range(0, NUM_CH - 1));
            2:       blk = BASE + 12'(NUM_CH);
            3:       blk = BASE + 12'(NUM_CH + 1);
            default: blk = 12'($urandom);
         endcase
         a  = {blk, 4'($urandom)};
         dw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT - 1)) : -1;
         bus_cycle(a, ($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)), dw);
         idle(int'($urandom_range(0, 3)));
      end
      idle(RST + 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
